// File: rtl/restoring_divider6.sv
// Sequential restoring divider: one quotient bit per clock through a shared ripple-borrow slice.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor to a one-cycle result.

module fsub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module restoring_divider6 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // R is kept WIDTH bits wide: a restored or subtracted remainder is always < D,
  // so the top bit of the WIDTH+1-bit partial remainder is always zero.
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] s, r_step;
  logic [WIDTH:0]   bw;
  logic             borrow;

  assign t     = {r_q, q_q[WIDTH-1]};
  assign bw[0] = 1'b0;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_sub
      fsub_cell u_cell (
        .a_i   (t[i]),
        .b_i   (d_q[i]),
        .bin_i (bw[i]),
        .d_o   (s[i]),
        .bout_o(bw[i+1])
      );
    end
  endgenerate

  // Top slice sees a zero divisor bit, so only its borrow-out is needed.
  assign borrow = ~t[WIDTH] & bw[WIDTH];
  assign r_step = borrow ? t[WIDTH-1:0] : s;

`ifdef DIV_ZERO_DETECT_EN
  logic dz_q, dz_d;
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        q_d     = dividend;
        d_d     = divisor;
        r_d     = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        r_d   = r_step;
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = {q_q[WIDTH-2:0], ~borrow};
          rem_d   = r_step;
          state_d = DONE;
`ifdef DIV_ZERO_DETECT_EN
          dz_d    = 1'b0;
`endif
        end
`ifdef DIV_ZERO_DETECT_EN
        // First RUN cycle still holds the dividend in Q.
        if (d_q == '0) begin
          quo_d   = '1;
          rem_d   = q_q;
          dz_d    = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: doc/restoring_divider6.md
# restoring_divider6

Sequential unsigned integer divider. It reuses one ripple-borrow subtractor slice, built from full-subtractor cells, across multiple cycles. The controller sequences a shift-and-subtract (restoring) algorithm, one quotient bit per clock, behind a start/done handshake. It sits beside the combinational subtractor datapath and is the first multi-cycle arithmetic unit built on it.

## Interface
Parameters:
- `WIDTH`, default 6: operand, quotient and remainder width. Legal range 2–16.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a division; sampled only in IDLE.
- `dividend`  input  WIDTH  unsigned dividend; captured on the accepted `start` edge.
- `divisor`  input  WIDTH  unsigned divisor; captured on the accepted `start` edge.
- `busy`  output  1  high while iterating.
- `done`  output  1  one-cycle pulse; results valid from this cycle on.
- `quotient`  output  WIDTH  result; held until the next result is written.
- `remainder`  output  WIDTH  result; held until the next result is written.
- `div_by_zero`  output  1  high together with, and held alongside, a divide-by-zero result.

## Operation
FSM states: IDLE, RUN, DONE.
- **IDLE:** on `start=1`:
  - capture the operands into Q (dividend) and D (divisor);
  - clear the partial remainder R (WIDTH+1 bits) and the iteration counter;
  - go to RUN.
- **RUN, per cycle:**
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - S = T − {1'b0, D}, computed by a WIDTH+1-bit ripple-borrow chain.
  - Borrow-out 0: R←S, Q←{Q[WIDTH-2:0],1}.
  - Borrow-out 1 (restore): R←T, Q←{Q[WIDTH-2:0],0}.
  - Counter increments each cycle. After WIDTH iterations, write `quotient`←Q and `remainder`←R[WIDTH-1:0], then go to DONE.
- **DONE:**
  - `done=1` for exactly one cycle, then return to IDLE.
  - `start` is ignored in DONE.
- `start` is ignored in RUN: no restart, no queueing.
- Arithmetic is unsigned only. The divisor is zero-extended to WIDTH+1 bits. The borrow chain must not truncate T's top bit.
- Divisor 0 without the fast path:
  - every step has no borrow;
  - the result is `quotient`=all ones and `remainder`=dividend.
  - The fast path (see Configuration) must produce these identical values.
- Asynchronous reset at any time, including mid-RUN, forces:
  - IDLE;
  - `busy=0`, `done=0`, `div_by_zero=0`;
  - `quotient=0`, `remainder=0`;
  - internal R, Q and counter cleared.

  After reset, a fresh `start` is required.

## Timing
- Reset values: all outputs 0.
- Call the edge that samples `start=1` in IDLE edge 0.
  - `busy` is high after edge 0.
  - `done` rises after edge WIDTH; `busy` falls on the same edge.
  - `done` falls after edge WIDTH+1, back in IDLE.
  - The default WIDTH=6 gives a latency of 6 cycles from accept to `done`.
- The next `start` is accepted at edge WIDTH+2 at the earliest. Throughput is one division per WIDTH+2 cycles.
- `quotient`, `remainder` and `div_by_zero` change only on the edge that raises `done`. They are stable for every other cycle, including throughout the next RUN.
- Operands may change after edge 0 without affecting the result.

## Configuration
Macro: `DIV_ZERO_DETECT_EN`.
- **Defined:**
  - a divisor of 0 at accept bypasses RUN and goes directly to DONE;
  - `done` is high after edge 1;
  - `quotient`=all ones, `remainder`=dividend, `div_by_zero=1`.

  `div_by_zero` is cleared on the next result write.
- **Undefined:**
  - `div_by_zero` is tied to 0;
  - a zero divisor takes the full WIDTH-cycle path, with the same quotient and remainder values.

## Test plan
- 42 / 5 (6'b101010 / 6'b000101) → `done` 6 cycles after accept, `quotient`=8, `remainder`=2, `busy` high for exactly 6 cycles.
- 63/1 → 63 r 0; 5/9 → 0 r 5; 36/6 → 6 r 0. Back-to-back `start` held high must yield one result per 8 cycles.
- 37 / 0:
  - with `DIV_ZERO_DETECT_EN` → `done` after 1 cycle, `quotient`=63, `remainder`=37, `div_by_zero=1`;
  - without it → `done` after 6 cycles, same values, `div_by_zero=0`.
- `start` pulsed with 10/3 at cycle 2 of a 42/5 run → ignored. Result is 8 r 2, and no second `done`.
- `rst_n` low at cycle 3 of a run → all outputs 0 immediately (asynchronously). No `done` after release. A following 20/4 gives 5 r 0.
- Operands changed to 1/1 the cycle after accepting 42/5 → result still 8 r 2.
